// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: Moore FSM that drives datapath strobes and
// mux selects for lw/sw/R-type/beq/bne/addi/j, one instruction phase per state.
module multicycle_ctrl #(
    parameter bit ENABLE_BNE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic [2:0] alu_ctrl,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  REXE   = 4'd6,  RWB    = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_d, state_q;
    // Branch flavour captured in DECODE so BRANCH never has to look at op.
    logic   is_bne_d, is_bne_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            is_bne_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_bne_q <= is_bne_d;
        end
    end

    always_comb begin
        state_d  = FETCH;
        is_bne_d = is_bne_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                is_bne_d = (op == OP_BNE);
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = REXE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_BNE:       state_d = ENABLE_BNE ? BRANCH : FETCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = MEMWB;
            REXE:   state_d = RWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        alu_ctrl   = ALU_ADD;
        case (state_q)
            FETCH: begin
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                pc_en     = 1'b1;
            end
            DECODE: alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            REXE: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
            end
            RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = is_bne_q ? (ENABLE_BNE && !zero) : zero;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: ENABLE_BNE, default 1, meaning 1 = decode opcode 000101 (bne); 0 = treat it as illegal.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: op  input  6  opcode field from the instruction register (instr[31:26]).
REQ-005 Port: funct  input  6  funct field from the instruction register (instr[5:0]).
REQ-006 Port: zero  input  1  ALU zero flag, sampled in the branch state.
REQ-007 Ports: ir_write, mem_write, reg_write, iord, reg_dst, mem_to_reg, alu_src_a; each output, 1 bit, datapath strobe or mux select.
REQ-008 Port: alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-009 Port: pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], jta, 00}.
REQ-010 Port: pc_en  output  1  PC load enable.
REQ-011 Port: alu_ctrl  output  3  ALU operation select.
REQ-012 Port: state  output  4  current FSM state, for debug and verification.

Function
REQ-013 The block SHALL be a Moore FSM; every output except pc_en and alu_ctrl SHALL be a pure function of the state register.
REQ-014 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXE=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-015 Transitions: FETCH->DECODE unconditionally.
REQ-016 Transitions from DECODE by op: lw 100011 / sw 101011 -> MEMADR; 000000 -> REXE; beq 000100 (and bne 000101 when ENABLE_BNE=1) -> BRANCH; addi 001000 -> ADDIEX; j 000010 -> JUMP; any other opcode -> FETCH (illegal instruction, no architectural write).
REQ-017 Transitions from MEMADR: lw -> MEMRD; sw -> MEMWR.
REQ-018 Remaining transitions: MEMRD->MEMWB; REXE->RWB; ADDIEX->ADDIWB.
REQ-019 The states MEMWB, MEMWR, RWB, BRANCH, ADDIWB and JUMP SHALL each go to FETCH.
REQ-020 Unused encodings 12-15 SHALL go to FETCH on the next edge and SHALL assert no write strobe.
REQ-021 FETCH SHALL assert: ir_write=1, iord=0, alu_src_a=0, alu_src_b=01, ALU add, pc_src=00, PC write.
REQ-022 DECODE SHALL assert: alu_src_a=0, alu_src_b=11, ALU add (branch target into ALUOut); no write strobes.
REQ-023 MEMADR SHALL assert: alu_src_a=1, alu_src_b=10, ALU add.
REQ-024 MEMRD SHALL assert iord=1.
REQ-025 MEMWB SHALL assert: reg_write=1, reg_dst=0, mem_to_reg=1.
REQ-026 MEMWR SHALL assert: iord=1, mem_write=1.
REQ-027 REXE SHALL assert: alu_src_a=1, alu_src_b=00, ALU op taken from funct.
REQ-028 RWB SHALL assert: reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-029 BRANCH SHALL assert: alu_src_a=1, alu_src_b=00, ALU sub, pc_src=01.
REQ-030 ADDIEX SHALL assert: alu_src_a=1, alu_src_b=10, ALU add.
REQ-031 ADDIWB SHALL assert: reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-032 JUMP SHALL assert pc_src=10 and PC write.
REQ-033 pc_en SHALL be asserted in FETCH and JUMP.
REQ-034 In BRANCH, pc_en SHALL be asserted when (beq and zero=1) or (bne, ENABLE_BNE=1 and zero=0); zero SHALL be ignored in every other state.
REQ-035 alu_ctrl for funct-driven ALU ops: funct 100000 add=010; 100010 sub=110; 100100 and=000; 100101 or=001; 101010 slt=111; any other funct = 010.
REQ-036 alu_ctrl for fixed ALU ops: add=010, sub=110.
REQ-037 In states with no ALU use, alu_ctrl SHALL be 010.
REQ-038 Instruction latency in cycles, FETCH through the writeback or final state inclusive: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
REQ-039 op and funct SHALL be read only in DECODE, MEMADR and REXE, so the instruction register stays stable while ir_write=0.

Reset
REQ-040 reset=1 SHALL force state=FETCH immediately, with no clock required, including mid-instruction.
REQ-041 During reset, outputs SHALL equal the FETCH decode: ir_write=1, pc_en=1, iord=0, alu_src_b=01, alu_ctrl=010.
REQ-042 During reset, mem_write and reg_write SHALL be 0.
REQ-043 After reset deasserts, the first rising edge SHALL move the FSM to DECODE.

Verification
REQ-044 lw: op=100011 -> state sequence 0,1,2,3,4,0; mem_to_reg=1 and reg_write=1 only in state 4; iord=1 in state 3.
REQ-045 sw and R-type: sw gives 0,1,2,5,0 with mem_write=1 only in state 5; R-type with funct=100010 gives 0,1,6,7,0 with alu_ctrl=110 in state 6.
REQ-046 Branch: beq with zero=1 -> pc_en=1 and pc_src=01 in state 8; beq with zero=0 -> pc_en=0 in state 8; bne with ENABLE_BNE=0 -> illegal path 0,1,0.
REQ-047 Jump and illegal: op=000010 -> state 11 with pc_src=10 and pc_en=1; op=111111 -> 0,1,0 with no write strobe asserted.
REQ-048 Reset mid-operation: assert reset asynchronously while in state 3 (MEMRD) -> state=0 before the next edge, reg_write never asserted, and normal fetch resumes after release.
